// File: rtl/insn_prefetch_queue.sv
// insn_prefetch_queue: owns the fetch PC, issues one imem word request per cycle and buffers {instr, pc} for ID
module insn_prefetch_queue #(
  parameter int PC_W = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [INS_W-1:0]             imem_rdata,
  output logic                         out_valid,
  output logic [INS_W-1:0]             out_instr,
  output logic [PC_W-1:0]              out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [PC_W-1:0] fetch_pc, inflight_pc;
  logic inflight, push, pop;
  logic [INS_W-1:0] fifo_instr [DEPTH];
  logic [PC_W-1:0] fifo_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign imem_req = !reset && !redirect_valid && (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign push = inflight && !redirect_valid;
  assign out_valid = !reset && !redirect_valid && (count != '0);
  assign pop = out_valid && out_ready;
  assign out_instr = fifo_instr[rd_ptr];
  assign out_pc = fifo_pc[rd_ptr];
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= '0;
      inflight_pc <= '0;
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr] <= inflight_pc;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc <= fetch_pc + PC_W'(4);
      end
    end
  end
endmodule

// File: tb/tb_insn_prefetch_queue.sv
// tb_insn_prefetch_queue: queue-level reference model checked every cycle, plus hand-computed pins
module tb_insn_prefetch_queue;
  localparam int PC_W = 9, INS_W = 32, DEPTH = 4, CW = 3;
  logic clock = 0, reset = 1, redirect_valid = 0, out_ready = 0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic [INS_W-1:0] imem_rdata = '0;
  logic imem_req, out_valid;
  logic [PC_W-1:0] imem_addr, out_pc;
  logic [INS_W-1:0] out_instr;
  logic [CW-1:0] count;
  int errors = 0, checks = 0;
  typedef struct { logic [31:0] ins; logic [8:0] pc; } ent_t;
  ent_t q[$];
  logic [8:0] m_fpc = 0, m_ipc = 0;
  bit m_inf = 0;
  logic o_req, o_val;
  logic [8:0] o_addr, o_pc;
  logic [31:0] o_ins;
  logic [2:0] o_cnt;

  insn_prefetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready), .count(count));

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [8:0] a);
    return {16'hC0DE, 7'h0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit rv, input logic [8:0] rpc, input bit rdy);
    bit e_req, e_val;
    logic [31:0] nxt;
    reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
    e_req = !rst && !rv && (q.size() + int'(m_inf) < DEPTH);
    e_val = !rst && !rv && q.size() != 0;
    chk("imem_req", imem_req, e_req);
    if (e_req) chk("imem_addr", imem_addr, m_fpc);
    chk("out_valid", out_valid, e_val);
    if (e_val) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].ins);
    end
    if (!rst) chk("count", count, q.size());
    o_req = imem_req; o_val = out_valid; o_addr = imem_addr; o_pc = out_pc; o_ins = out_instr; o_cnt = count;
    nxt = e_req ? word(m_fpc) : 32'h0;
    if (rst) begin
      q.delete(); m_fpc = 0; m_inf = 0;
    end else if (rv) begin
      q.delete(); m_inf = 0; m_fpc = rpc & 9'h1FC;
    end else begin
      if (e_val && rdy) void'(q.pop_front());
      if (m_inf) q.push_back('{word(m_ipc), m_ipc});
      m_inf = e_req;
      if (e_req) begin m_ipc = m_fpc; m_fpc = m_fpc + 9'd4; end
    end
    @(posedge clock);
    #1 imem_rdata = nxt;
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    // streaming from reset
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("c0_req", o_req, 1); chk("c0_addr", o_addr, 0); chk("c0_cnt", o_cnt, 0);
    chk("c0_pc_cleared", o_pc, 0); chk("c0_ins_cleared", o_ins, 0);
    cyc(0, 0, 0, 1);
    chk("c1_valid", o_val, 0);
    cyc(0, 0, 0, 1);
    chk("c2_valid", o_val, 1); chk("c2_pc", o_pc, 0); chk("c2_ins", o_ins, 32'hC0DE0000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("c5_pc", o_pc, 12); chk("c5_cnt", o_cnt, 1); chk("c5_req", o_req, 1);
    // backpressure
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("bp_req_drop", o_req, 0);
    cyc(0, 0, 0, 0);
    chk("bp_cnt_full", o_cnt, 4);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1);
      chk("bp_release_pc", o_pc, 9'(4 * i));
      chk("bp_release_valid", o_val, 1);
    end
    // redirect to 0x40 with count=3 and a fetch in flight
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 9'h040, 1);
    chk("rd_valid", o_val, 0); chk("rd_req", o_req, 0);
    cyc(0, 0, 0, 1);
    chk("rd1_addr", o_addr, 9'h040); chk("rd1_cnt", o_cnt, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rd3_pc", o_pc, 9'h040); chk("rd3_valid", o_val, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    // unaligned redirect while ID is ready
    cyc(0, 1, 9'h043, 1);
    chk("ru_valid", o_val, 0);
    cyc(0, 0, 0, 1);
    chk("ru_addr", o_addr, 9'h040); chk("ru_cnt", o_cnt, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("ru_pc", o_pc, 9'h040);
    // address wrap-around
    cyc(0, 1, 9'h1FC, 1);
    cyc(0, 0, 0, 1); chk("wr_a0", o_addr, 9'h1FC);
    cyc(0, 0, 0, 1); chk("wr_a1", o_addr, 9'h000);
    cyc(0, 0, 0, 1); chk("wr_a2", o_addr, 9'h004); chk("wr_p0", o_pc, 9'h1FC);
    cyc(0, 0, 0, 1); chk("wr_p1", o_pc, 9'h000);
    cyc(0, 0, 0, 1); chk("wr_p2", o_pc, 9'h004);
    // reset mid-stream with count=2
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); chk("mr_cnt2", o_cnt, 2);
    cyc(1, 0, 0, 1); chk("mr_valid", o_val, 0); chk("mr_req", o_req, 0);
    cyc(1, 0, 0, 1); chk("mr_cnt0", o_cnt, 0); chk("mr_req2", o_req, 0); chk("mr_valid2", o_val, 0);
    cyc(0, 0, 0, 1); chk("mr_addr", o_addr, 0); chk("mr_req3", o_req, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("mr_pc", o_pc, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/insn_prefetch_queue.md
# insn_prefetch_queue

Instruction prefetch queue between the synchronous instruction memory and the IF/ID pipeline register of the five-stage RISC-V core. It owns the fetch PC, issues one word request per cycle to instruction memory, and buffers returned instructions with their PCs in a small FIFO. The ID stage pops them with a valid/ready handshake, where ready is the inverse of the hazard-unit stall. A branch redirect from EX flushes all buffered and in-flight fetches and restarts fetch at the target.

## Interface
- PC_W, 9, byte-address width of fetch PC and instruction memory address
- INS_W, 32, instruction width
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- redirect_valid  in  1  branch/jump taken in EX (pc_sel); flush and refetch
- redirect_pc  in  PC_W  redirect target; bits [1:0] ignored (treated as 0)
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PC_W  word-aligned fetch address, valid when imem_req=1
- imem_rdata  in  INS_W  instruction for the request issued in the previous cycle
- out_valid  out  1  head entry available to ID
- out_instr  out  INS_W  head instruction
- out_pc  out  PC_W  head PC
- out_ready  in  1  ID accepts head this cycle (= !stall)
- count  out  $clog2(DEPTH+1)  occupied FIFO entries

## Operation
- State: fetch_pc (PC_W), inflight flag (1 outstanding request max), inflight_pc, FIFO of DEPTH {instr, pc} entries with rd_ptr/wr_ptr, and an occupancy counter.
- Issue rule: imem_req = !reset && !redirect_valid && (count + inflight < DEPTH). imem_addr = fetch_pc. On issue, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 modulo 2^PC_W (wraps to 0, no error), and inflight ← 1. Otherwise inflight ← 0.
- Response: if inflight=1 and no redirect this cycle, push {imem_rdata, inflight_pc} at wr_ptr. Credit accounting guarantees there is space for the push, so a push is never dropped for lack of room.
- Pop: out_valid = (count≠0) && !redirect_valid. The pop fires when out_valid && out_ready and advances rd_ptr. out_instr and out_pc are driven combinationally from the head entry (first-word fall-through). They are don't-care when out_valid=0.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Redirect (highest priority after reset):
  - At the edge, count ← 0, pointers ← 0, inflight ← 0.
  - Any response arriving in the redirect cycle is discarded.
  - A pop in the same cycle is suppressed.
  - fetch_pc ← {redirect_pc[PC_W-1:2], 2'b00}.
  - No request is issued in the redirect cycle; fetch resumes on the next cycle.
- Reset: fetch_pc=0, count=0, pointers=0, inflight=0. Outputs during and after reset: imem_req=0 while reset=1, out_valid=0, count=0. out_instr and out_pc read the cleared entry (0).
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never goes negative; a pop when empty is impossible because out_valid=0.

## Timing
- Instruction memory latency is fixed at 1 cycle: data for an address presented in cycle t is on imem_rdata in cycle t+1.
- Fetch-to-ID latency is 2 cycles: request in cycle t, push at the end of t+1, out_valid=1 in t+2.
- After reset deasserts (first cycle with reset=0 is c0): imem_req=1 with addr 0 in c0; out_valid=1 with out_pc=0 in c2.
- Sustained throughput with out_ready=1 is 1 instruction/cycle in steady state (count=1, inflight=1).
- With out_ready=0, requests stop once count+inflight=DEPTH. The FIFO reaches count=DEPTH one cycle later.
- Redirect asserted in cycle r: the target request issues in r+1 and the first target instruction is valid in r+3.

## Test plan
- Reset then stream with out_ready=1 and imem model holding word i at address 4i: out_pc sequence 0,4,8,… from cycle 2; one pop per cycle; count stays at 1; imem_req stays high.
- Backpressure: out_ready=0 from cycle 2. imem_req drops once count+inflight=4; count settles at 4; addresses 0..12 are held. Release out_ready: pops 0,4,8,12 on consecutive cycles, then 16 follows with no gap.
- Redirect to 0x40 while count=3 and a fetch is in flight: out_valid=0 in the redirect cycle; the stale response is discarded; imem_addr=0x40 in r+1; out_pc=0x40 in r+3; no stale PC ever appears on out_pc.
- Redirect with redirect_pc=0x43 while out_ready=1: no pop in that cycle; fetch restarts at 0x40.
- Wrap-around: redirect to 0x1FC (PC_W=9). Issued addresses are 0x1FC, 0x000, 0x004; out_pc follows the same sequence.
- Reset asserted mid-stream with count=2: the next cycle has count=0, out_valid=0, imem_req=0. After release, fetch restarts at 0.
